// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npu_pkg
// Description : Shared NPU constants and types for the convolution datapath.
//               A row result vector holds one entry per valid kernel
//               position across a pixel row.
// Revision    : 1.0 - initial release
// ============================================================================
package npu_pkg;

    localparam int PIXEL_ROW_BYTES = 32;
    localparam int KERNEL_TAPS     = 3;
    localparam int NUM_RESULTS     = PIXEL_ROW_BYTES - KERNEL_TAPS + 1;
    localparam int RESULT_W        = 18;
    localparam int IDX_W           = 5;

    typedef logic signed [RESULT_W-1:0] result_t;

endpackage : npu_pkg
`default_nettype wire

// File: rtl/conv_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : conv_result_streamer
// Description : Snapshots the convolution engine's row result vector on the
//               one-cycle done pulse and streams the entries out, index 0
//               first, over a valid/ready interface. A new row may complete
//               exactly on the final handshake (back-to-back, no bubble);
//               a row completing at any other point of a stream is dropped
//               and reported as an overrun.
// Ports       : clk            - clock, rising edge
//               rst            - synchronous active-high reset
//               done_signal    - engine row-complete pulse, result_data valid
//               result_data    - [0:NUM_RESULTS-1] signed row results
//               m_valid/m_ready- output handshake
//               m_data         - current result
//               m_index        - index of current result
//               m_last         - marks index NUM_RESULTS-1
//               busy           - a stream is in progress
//               overrun        - one-cycle pulse, a done pulse was dropped
//               overrun_sticky - set on any overrun, cleared only by rst
// Options     : CONV_RESULT_RELU_EN - when defined, negative entries are
//               stored as 0 at capture (ReLU); otherwise raw two's complement.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_result_streamer #(
    parameter int NUM_RESULTS = npu_pkg::NUM_RESULTS,
    parameter int RESULT_W    = npu_pkg::RESULT_W,
    parameter int IDX_W       = npu_pkg::IDX_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       done_signal,
    input  logic signed [RESULT_W-1:0] result_data [0:NUM_RESULTS-1],
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic signed [RESULT_W-1:0] m_data,
    output logic [IDX_W-1:0]           m_index,
    output logic                       m_last,
    output logic                       busy,
    output logic                       overrun,
    output logic                       overrun_sticky
);

    import npu_pkg::*;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_RESULTS - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nx;
    logic [IDX_W-1:0]            r_index;
    logic [IDX_W-1:0]            w_index_nx;
    logic                        r_overrun;
    logic                        w_overrun_nx;
    logic                        r_overrun_sticky;
    logic                        w_capture;
    logic                        w_valid;
    logic                        w_last;
    logic                        w_handshake;
    logic signed [RESULT_W-1:0]  r_buf   [0:NUM_RESULTS-1];
    logic signed [RESULT_W-1:0]  w_store [0:NUM_RESULTS-1];

    // Value written into the snapshot buffer for each entry.
    for (genvar gi = 0; gi < NUM_RESULTS; gi++) begin : g_store
`ifdef CONV_RESULT_RELU_EN
        assign w_store[gi] = result_data[gi][RESULT_W-1] ? '0 : result_data[gi];
`else
        assign w_store[gi] = result_data[gi];
`endif
    end

    assign w_valid     = (r_state == ST_STREAM);
    assign w_last      = w_valid && (r_index == c_LAST_IDX);
    assign w_handshake = w_valid && m_ready;

    always_comb begin
        w_state_nx   = r_state;
        w_index_nx   = r_index;
        w_capture    = 1'b0;
        w_overrun_nx = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (done_signal) begin
                    w_capture  = 1'b1;
                    w_state_nx = ST_STREAM;
                    w_index_nx = '0;
                end
            end
            ST_STREAM: begin
                if (w_handshake && w_last) begin
                    // Final beat accepted: the buffer is free, so a done
                    // pulse in this very cycle is a legal back-to-back row.
                    w_index_nx = '0;
                    if (done_signal) begin
                        w_capture = 1'b1;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end else begin
                    if (w_handshake) begin
                        w_index_nx = r_index + 1'b1;
                    end
                    // Buffer still holds undrained entries: drop the new row.
                    if (done_signal) begin
                        w_overrun_nx = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_index_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_index          <= '0;
            r_overrun        <= 1'b0;
            r_overrun_sticky <= 1'b0;
        end else begin
            r_state          <= w_state_nx;
            r_index          <= w_index_nx;
            r_overrun        <= w_overrun_nx;
            r_overrun_sticky <= r_overrun_sticky | w_overrun_nx;
        end
    end

    // Snapshot buffer needs no reset: it is only read while streaming,
    // and every stream begins with a full capture.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int i = 0; i < NUM_RESULTS; i++) begin
                r_buf[i] <= w_store[i];
            end
        end
    end

    assign m_valid        = w_valid;
    assign busy           = w_valid;
    assign m_last         = w_last;
    assign m_index        = w_valid ? r_index : '0;
    assign m_data         = w_valid ? r_buf[r_index] : '0;
    assign overrun        = r_overrun;
    assign overrun_sticky = r_overrun_sticky;

endmodule : conv_result_streamer
`default_nettype wire
